// File: rtl/ra_pq_arb.sv
// ra_pq_arb: round-robin arbiter in front of a replace/dequeue priority queue.
// Grants are combinational and the popped head comes back registered one cycle
// later. Dequeues from an empty queue are answered with an error and never
// reach the queue.

package ra_pq_pkg;
  localparam int KEY_W = 16;
  localparam int VAL_W = 16;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYNEGINF = '0;
  localparam logic [KEY_W-1:0] KEYINF    = '1;
  localparam logic [VAL_W-1:0] VAL0      = '0;
  localparam kv_t              KV_IDLE   = '{key: KEYINF, val: VAL0};
endpackage

module ra_pq_arb
  import ra_pq_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = $clog2(N_CLIENTS),
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  input  logic [N_CLIENTS-1:0] op,
  input  kv_t                  cl_kvi [N_CLIENTS],
  output logic [N_CLIENTS-1:0] gnt,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output kv_t                  resp_kv,
  output logic                 resp_err,
  output kv_t                  pq_kvi,
  output logic                 pq_replace,
  output logic                 pq_deq,
  input  kv_t                  pq_kvo,
  input  logic                 pq_full,
  input  logic                 pq_empty,
  input  logic                 pq_busy,
  output logic [CNT_W-1:0]     n_replace,
  output logic [CNT_W-1:0]     n_deq,
  output logic [CNT_W-1:0]     n_err
);

  localparam logic [ID_W:0]      NC   = (ID_W+1)'(N_CLIENTS);
  localparam logic [ID_W-1:0]    LAST = ID_W'(N_CLIENTS - 1);

  // Replace is legal on a full queue, so the full flag plays no part in arbitration.
  logic unused_status;
  assign unused_status = pq_full;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // First eligible index at or after p, wrapping modulo N_CLIENTS; MSB = found.
  function automatic logic [ID_W:0] rr_pick(input logic [N_CLIENTS-1:0] e,
                                            input logic [ID_W-1:0]      p);
    logic [ID_W:0]   sum;
    logic            found;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      sum = {1'b0, p} + (ID_W+1)'(i);
      if (sum >= NC) sum = sum - NC;
      if (!found && e[sum[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = sum[ID_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  logic [ID_W-1:0]      ptr;
  logic [N_CLIENTS-1:0] elig;
  logic [ID_W:0]        pick;
  logic                 any_gnt;
  logic [ID_W-1:0]      gid;
  logic                 g_op;
  logic                 rej;

  // Nothing is eligible while the queue is busy or while reset is held.
  assign elig    = req & ~{N_CLIENTS{pq_busy}} & {N_CLIENTS{rst}};
  assign pick    = rr_pick(elig, ptr);
  assign any_gnt = pick[ID_W];
  assign gid     = pick[ID_W-1:0];
  assign g_op    = op[gid];

  // Stage 0: combinational grant and queue strobes.
  always_comb begin
    gnt        = '0;
    pq_kvi     = KV_IDLE;
    pq_replace = 1'b0;
    pq_deq     = 1'b0;
    rej        = 1'b0;
    if (any_gnt) begin
      gnt        = N_CLIENTS'(1) << gid;
      pq_kvi     = cl_kvi[gid];
      pq_replace = g_op;
      pq_deq     = ~g_op & ~pq_empty;
      rej        = ~g_op & pq_empty;
    end
  end

  // Round-robin pointer moves just past the granted client, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (gid == LAST) ? '0 : gid + 1'b1;
    end
  end

  // Stage 1: response register, loaded on a grant and held otherwise.
  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  kv_t             kv_p1;
  logic            err_p1;

  // Capture the head popped by this cycle's operation, or the idle pair on a rejection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
      kv_p1  <= KV_IDLE;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= any_gnt;
      if (any_gnt) begin
        id_p1  <= gid;
        kv_p1  <= rej ? KV_IDLE : pq_kvo;
        err_p1 <= rej;
      end
    end
  end

  assign resp_valid = vld_p1;
  assign resp_id    = id_p1;
  assign resp_kv    = kv_p1;
  assign resp_err   = err_p1;

  // Saturating operation statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_replace <= '0;
      n_deq     <= '0;
      n_err     <= '0;
    end else begin
      if (pq_replace) n_replace <= sat_inc(n_replace);
      if (pq_deq)     n_deq     <= sat_inc(n_deq);
      if (rej)        n_err     <= sat_inc(n_err);
    end
  end

endmodule

// File: tb/tb_ra_pq_arb.sv
// Directed self-checking bench for ra_pq_arb with four clients; a second
// instance with 2-bit counters exercises saturation.
module tb_ra_pq_arb;
  import ra_pq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] op;
  kv_t        cl_kvi [4];
  kv_t        pq_kvo;
  logic       pq_full, pq_empty, pq_busy;

  logic [3:0]  gnt;
  logic        resp_valid;
  logic [1:0]  resp_id;
  kv_t         resp_kv;
  logic        resp_err;
  kv_t         pq_kvi;
  logic        pq_replace, pq_deq;
  logic [15:0] n_replace, n_deq, n_err;

  logic [3:0] unused_s_gnt;
  logic       unused_s_resp_valid;
  logic [1:0] unused_s_resp_id;
  kv_t        unused_s_resp_kv;
  logic       unused_s_resp_err;
  kv_t        unused_s_pq_kvi;
  logic       unused_s_pq_replace, unused_s_pq_deq;
  logic [1:0] s_n_replace, unused_s_n_deq, unused_s_n_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ra_pq_arb #(.N_CLIENTS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .cl_kvi(cl_kvi), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_kv(resp_kv), .resp_err(resp_err),
    .pq_kvi(pq_kvi), .pq_replace(pq_replace), .pq_deq(pq_deq), .pq_kvo(pq_kvo),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
    .n_replace(n_replace), .n_deq(n_deq), .n_err(n_err)
  );

  ra_pq_arb #(.N_CLIENTS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .op(op), .cl_kvi(cl_kvi), .gnt(unused_s_gnt),
    .resp_valid(unused_s_resp_valid), .resp_id(unused_s_resp_id), .resp_kv(unused_s_resp_kv),
    .resp_err(unused_s_resp_err), .pq_kvi(unused_s_pq_kvi), .pq_replace(unused_s_pq_replace),
    .pq_deq(unused_s_pq_deq), .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty),
    .pq_busy(pq_busy), .n_replace(s_n_replace), .n_deq(unused_s_n_deq), .n_err(unused_s_n_err)
  );

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op = '0; pq_kvo = 32'h1234_5678;
    pq_full = 1'b0; pq_empty = 1'b0; pq_busy = 1'b0;
    for (int i = 0; i < 4; i++) cl_kvi[i] = '0;
    #1 rst = 1'b0;
    req = 4'b1111; op = 4'b1111;
    @(posedge clk); #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (pq_replace !== 1'b0 || pq_deq !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%b%b exp=00", pq_replace, pq_deq); end
    checks++; if (pq_kvi !== 32'hFFFF_0000) begin failures++; $display("FAIL rst_pq_kvi got=%h exp=ffff0000", pq_kvi); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_id !== 2'd0) begin failures++; $display("FAIL rst_resp got=v%b e%b id%0d exp=v0 e0 id0", resp_valid, resp_err, resp_id); end
    checks++; if (resp_kv !== 32'hFFFF_0000) begin failures++; $display("FAIL rst_resp_kv got=%h exp=ffff0000", resp_kv); end
    checks++; if (n_replace !== 16'd0 || n_deq !== 16'd0 || n_err !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", n_replace, n_deq, n_err); end
    req = '0; op = '0;
    rst = 1'b1;
  endtask

  task automatic test_single_replace();
    cl_kvi[2] = '{key: 16'd5, val: 16'd9};
    pq_kvo = '{key: 16'h0000, val: 16'h00AA};
    op = 4'b0100; req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rep_gnt got=%b exp=0100", gnt); end
    checks++; if (pq_replace !== 1'b1 || pq_deq !== 1'b0) begin failures++; $display("FAIL rep_strobes got=%b%b exp=10", pq_replace, pq_deq); end
    checks++; if (pq_kvi !== 32'h0005_0009) begin failures++; $display("FAIL rep_pq_kvi got=%h exp=00050009", pq_kvi); end
    @(posedge clk); #1;
    req = '0;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin failures++; $display("FAIL rep_resp got=v%b id%0d exp=v1 id2", resp_valid, resp_id); end
    checks++; if (resp_kv !== 32'h0000_00AA || resp_err !== 1'b0) begin failures++; $display("FAIL rep_resp_kv got=%h e%b exp=000000aa e0", resp_kv, resp_err); end
    checks++; if (n_replace !== 16'd1) begin failures++; $display("FAIL rep_n_replace got=%0d exp=1", n_replace); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) cl_kvi[i] = '{key: 16'(i + 1), val: 16'h0100};
    op = 4'b1111; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (gnt !== (4'b0001 << (k % 4))) begin failures++; $display("FAIL fair_gnt%0d got=%b exp=%b", k, gnt, 4'b0001 << (k % 4)); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(k % 4)) begin failures++; $display("FAIL fair_resp%0d got=v%b id%0d exp=v1 id%0d", k, resp_valid, resp_id, k % 4); end
    end
    req = '0;
    checks++; if (n_replace !== 16'd8) begin failures++; $display("FAIL fair_n_replace got=%0d exp=8", n_replace); end
  endtask

  task automatic test_empty_deq();
    pq_empty = 1'b1; op = 4'b0000; req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL edeq_gnt got=%b exp=0010", gnt); end
    checks++; if (pq_deq !== 1'b0 || pq_replace !== 1'b0) begin failures++; $display("FAIL edeq_strobes got=%b%b exp=00", pq_replace, pq_deq); end
    @(posedge clk); #1;
    req = '0;
    checks++; if (resp_err !== 1'b1 || resp_id !== 2'd1 || resp_valid !== 1'b1) begin failures++; $display("FAIL edeq_resp got=e%b id%0d v%b exp=e1 id1 v1", resp_err, resp_id, resp_valid); end
    checks++; if (resp_kv !== 32'hFFFF_0000) begin failures++; $display("FAIL edeq_resp_kv got=%h exp=ffff0000", resp_kv); end
    checks++; if (n_err !== 16'd1 || n_deq !== 16'd0 || n_replace !== 16'd8) begin failures++; $display("FAIL edeq_counters got=%0d/%0d/%0d exp=err1 deq0 rep8", n_err, n_deq, n_replace); end
  endtask

  task automatic test_deq();
    pq_empty = 1'b0; pq_kvo = 32'h0033_0044; op = 4'b0000; req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL deq_gnt got=%b exp=0001", gnt); end
    checks++; if (pq_deq !== 1'b1 || pq_replace !== 1'b0) begin failures++; $display("FAIL deq_strobes got=%b%b exp=01", pq_replace, pq_deq); end
    @(posedge clk); #1;
    req = '0;
    checks++; if (resp_kv !== 32'h0033_0044 || resp_err !== 1'b0 || resp_id !== 2'd0) begin failures++; $display("FAIL deq_resp got=%h e%b id%0d exp=00330044 e0 id0", resp_kv, resp_err, resp_id); end
    checks++; if (n_deq !== 16'd1 || n_err !== 16'd1) begin failures++; $display("FAIL deq_counters got=deq%0d err%0d exp=deq1 err1", n_deq, n_err); end
    pq_kvo = 32'h7777_8888;
    #1;
    checks++; if (gnt !== 4'b0000 || pq_deq !== 1'b0) begin failures++; $display("FAIL idle_gnt got=%b d%b exp=0000 d0", gnt, pq_deq); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || resp_kv !== 32'h0033_0044 || resp_id !== 2'd0) begin failures++; $display("FAIL resp_hold got=v%b %h id%0d exp=v0 00330044 id0", resp_valid, resp_kv, resp_id); end
  endtask

  task automatic test_busy();
    do_reset();
    pq_busy = 1'b1; op = 4'b1001; req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== 4'b0000 || pq_replace !== 1'b0 || pq_deq !== 1'b0) begin failures++; $display("FAIL busy%0d got=%b r%b d%b exp=0000 r0 d0", k, gnt, pq_replace, pq_deq); end
      @(posedge clk);
    end
    #1;
    checks++; if (resp_valid !== 1'b0 || n_replace !== 16'd0) begin failures++; $display("FAIL busy_idle got=v%b n%0d exp=v0 n0", resp_valid, n_replace); end
    pq_busy = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001 || pq_replace !== 1'b1) begin failures++; $display("FAIL busy_release got=%b r%b exp=0001 r1", gnt, pq_replace); end
    @(posedge clk); #1;
    checks++; if (resp_id !== 2'd0 || resp_valid !== 1'b1) begin failures++; $display("FAIL busy_resp0 got=id%0d v%b exp=id0 v1", resp_id, resp_valid); end
    req = 4'b1000;
    #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL busy_next got=%b exp=1000", gnt); end
    @(posedge clk); #1;
    checks++; if (resp_id !== 2'd3 || resp_valid !== 1'b1) begin failures++; $display("FAIL busy_resp3 got=id%0d v%b exp=id3 v1", resp_id, resp_valid); end
  endtask

  task automatic test_mid_reset();
    cl_kvi[1] = 32'h0042_0043; op = 4'b0010; req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010 || pq_replace !== 1'b1 || resp_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre got=%b r%b v%b exp=0010 r1 v1", gnt, pq_replace, resp_valid); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || pq_replace !== 1'b0) begin failures++; $display("FAIL mrst_gnt got=%b r%b exp=0000 r0", gnt, pq_replace); end
    checks++; if (resp_valid !== 1'b0 || resp_kv !== 32'hFFFF_0000 || n_replace !== 16'd0) begin failures++; $display("FAIL mrst_regs got=v%b %h n%0d exp=v0 ffff0000 n0", resp_valid, resp_kv, n_replace); end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    op = 4'b0000; pq_empty = 1'b0; req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001 || pq_deq !== 1'b1) begin failures++; $display("FAIL mrst_ptr got=%b d%b exp=0001 d1", gnt, pq_deq); end
    @(posedge clk); #1;
    req = '0;
    checks++; if (n_deq !== 16'd1 || n_replace !== 16'd0 || n_err !== 16'd0) begin failures++; $display("FAIL mrst_counters got=%0d/%0d/%0d exp=rep0 deq1 err0", n_replace, n_deq, n_err); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    do_reset();
    op = 4'b0001; req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (s_n_replace !== exp_sat[k]) begin failures++; $display("FAIL sat%0d got=%0d exp=%0d", k, s_n_replace, exp_sat[k]); end
      checks++; if (n_replace !== 16'(k + 1)) begin failures++; $display("FAIL wide%0d got=%0d exp=%0d", k, n_replace, k + 1); end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_replace();
    test_fairness();
    test_empty_deq();
    test_deq();
    test_busy();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ra_pq_arb.md
# ra_pq_arb

Round-robin arbiter that shares one replace/dequeue priority-queue device (pq_rd_if device side: kvi, kvo, replace, deq, full, empty, busy) among N_CLIENTS requesters. Each cycle it selects at most one pending request, drives the queue's replace or deq strobe, captures the popped head key-value pair and returns it to the granted client one cycle later. It rejects dequeues from an empty queue without touching the queue. It also keeps saturating operation statistics. It sits between client logic (schedulers, sorters) and any queue instance on pq_rd_if.

## Interface
- N_CLIENTS, 4: number of requesters, 2..16.
- ID_W, $clog2(N_CLIENTS): client index width.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_CLIENTS  per-client request, level, held until granted.
- op  in  N_CLIENTS  per-client operation: 1 = replace, 0 = dequeue.
- cl_kvi  in  N_CLIENTS x kv_t  per-client replace key-value; ignored for dequeue.
- gnt  out  N_CLIENTS  one-hot accept, combinational, same cycle as the request.
- resp_valid  out  1  response valid, registered, one cycle after gnt.
- resp_id  out  ID_W  index of the client being answered.
- resp_kv  out  kv_t  popped head pair.
- resp_err  out  1  dequeue was rejected because the queue was empty.
- pq_kvi  out  kv_t  to queue kvi; equals cl_kvi of the granted client, else {KEYINF,VAL0}.
- pq_replace  out  1  to queue replace.
- pq_deq  out  1  to queue deq.
- pq_kvo  in  kv_t  queue head.
- pq_full / pq_empty / pq_busy  in  1 each  queue status.
- n_replace / n_deq / n_err  out  CNT_W each  saturating statistics.

## Operation
- Eligible set: req & ~{N_CLIENTS{pq_busy}}. While pq_busy=1, gnt=0, pq_replace=0 and pq_deq=0.
- Round-robin arbitration:
  - ptr (ID_W bits) marks the highest-priority index.
  - Grant the first eligible index scanning ptr, ptr+1, … with wrap modulo N_CLIENTS.
  - On any grant, ptr <= granted index + 1, wrapping N_CLIENTS-1 to 0.
  - With no grant, ptr holds.
- Granted replace: pq_replace=1, pq_kvi=cl_kvi[g]. The popped pair is pq_kvo sampled at that edge. Replace is legal when full or empty.
- Granted dequeue with pq_empty=0: pq_deq=1, and pq_kvo is captured.
- Granted dequeue with pq_empty=1:
  - Issue no queue strobe.
  - The client still gets gnt and a response with resp_err=1 and resp_kv={KEYINF,VAL0}.
- pq_replace and pq_deq are mutually exclusive and never asserted without a gnt bit.
- Response register: resp_valid <= |gnt; resp_id, resp_kv and resp_err load on a grant and hold otherwise.
- Statistics:
  - n_replace increments per issued replace.
  - n_deq increments per issued dequeue.
  - n_err increments per rejected dequeue.
  - Each counter saturates at all-ones.
- Dummy keys (KEYNEGINF, KEYINF) are returned unfiltered. Interpreting them is the client's job.

## Timing
- Grant latency: 0 cycles. gnt and the queue strobes are combinational from req, op, ptr, pq_busy and pq_empty.
- Response latency: 1 cycle. Throughput: 1 operation per cycle.
- Clients drop req the cycle after gnt or present a new request. A request still asserted after gnt is a new request.
- Reset (rst=0, at any time, including mid-grant):
  - Immediately: resp_valid=0, resp_id=0, resp_kv={KEYINF,VAL0}, resp_err=0, ptr=0 and all counters 0.
  - gnt, pq_replace and pq_deq are forced 0 while rst=0.
  - The first grant is possible in the first cycle with rst=1.
- If pq_busy rises while req is held, the request waits with no gnt and is granted in the first cycle with pq_busy=0, following ptr order.

## Test plan
- Single replace: client 2 requests replace {key=5,val=9} while the queue head is KEYNEGINF.
  - Same cycle: gnt=4'b0100 and pq_replace=1.
  - Next cycle: resp_valid=1, resp_id=2, resp_kv.key=KEYNEGINF, resp_err=0, n_replace=1.
- Fairness: all 4 clients hold req for 8 cycles with ptr=0 → gnt sequence 0,1,2,3,0,1,2,3. No client is granted twice before every other requester has been granted once.
- Empty dequeue: with pq_empty=1, client 1 requests dequeue.
  - Same cycle: gnt=4'b0010, pq_deq=0.
  - Next cycle: resp_err=1, resp_kv.key=KEYINF, n_err=1, n_deq=0.
- Busy hold-off: pq_busy=1 for 3 cycles while clients 0 and 3 hold req → no gnt and no strobes during those cycles. First cycle with pq_busy=0 grants client 0 (ptr=0).
- Mid-operation reset: rst=0 asserted asynchronously during a granted replace.
  - gnt, pq_replace and resp_valid drop to 0 before the next edge.
  - After release, ptr=0 and all counters are 0.
- Saturation with CNT_W=2: 5 consecutive replaces → n_replace reads 1,2,3,3,3.
